// File: rtl/spi_master_driver.sv
// spi_master_driver: SPI master sending R/W+address, gap and data frames on a divided bus clock.
// Define SPI_MASTER_LOOPBACK_EN to add i_LOOPBACK, which feeds o_MOSI into the receive register.
module spi_master_driver #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV = 2,
  parameter int GAP_CLKS = 8
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_START,
  input  logic i_READ,
  input  logic [ADDRESS_WIDTH-2:0] i_ADDR,
  input  logic [DATA_WIDTH-1:0] i_DATA,
  output logic o_BUSY,
  output logic o_DONE,
  output logic [DATA_WIDTH-1:0] o_RDATA,
  output logic o_BCLK,
  output logic o_SS,
  output logic o_MOSI,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic i_LOOPBACK,
`endif
  input  logic i_MISO
);
  localparam int HW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam int GW = $clog2(GAP_CLKS) + 1;
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [BW-1:0] A_LAST = BW'(ADDRESS_WIDTH - 1);
  localparam logic [BW-1:0] D_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] B_ONE = BW'(1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CLKS - 1);
  localparam logic [GW-1:0] G_ONE = GW'(1);
  typedef enum logic [2:0] {IDLE, SETUP, ADDR, GAP, DATA, HOLD, DONE} state_t;
  state_t state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [ADDRESS_WIDTH-1:0] asr, asr_n;
  logic [DATA_WIDTH-1:0] dsr, dsr_n, rx, rx_n, rdata_n;
  logic rd, rd_n, bclk_n, ss_n, mosi_n, busy_n, done_n, miso, half_end, bit_end;
`ifdef SPI_MASTER_LOOPBACK_EN
  assign miso = i_LOOPBACK ? o_MOSI : i_MISO;
`else
  assign miso = i_MISO;
`endif
  assign half_end = hcnt == H_LAST;
  // A bit ends on the last cycle of its high half; that is also the receive sample point.
  assign bit_end = half_end && o_BCLK;
  always_comb begin
    state_n = state;
    hcnt_n = half_end ? '0 : hcnt + H_ONE;
    bcnt_n = bcnt;
    gcnt_n = gcnt;
    asr_n = asr;
    dsr_n = dsr;
    rx_n = rx;
    rd_n = rd;
    rdata_n = o_RDATA;
    bclk_n = o_BCLK;
    ss_n = o_SS;
    mosi_n = o_MOSI;
    busy_n = o_BUSY;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        hcnt_n = '0;
        if (i_START) begin
          state_n = SETUP;
          asr_n = {i_READ, i_ADDR};
          dsr_n = i_DATA;
          rd_n = i_READ;
          ss_n = 1'b0;
          busy_n = 1'b1;
          mosi_n = i_READ;
        end
      end
      SETUP: if (half_end) begin
        state_n = ADDR;
        bcnt_n = '0;
      end
      ADDR: begin
        if (half_end) bclk_n = ~o_BCLK;
        if (bit_end) begin
          if (bcnt == A_LAST) begin
            state_n = GAP;
            gcnt_n = '0;
          end else begin
            bcnt_n = bcnt + B_ONE;
            asr_n = asr << 1;
            mosi_n = asr[ADDRESS_WIDTH-2];
          end
        end
      end
      GAP: begin
        hcnt_n = '0;
        gcnt_n = gcnt + G_ONE;
        if (gcnt == G_LAST) begin
          state_n = DATA;
          bcnt_n = '0;
          mosi_n = dsr[DATA_WIDTH-1];
        end
      end
      DATA: begin
        if (half_end) bclk_n = ~o_BCLK;
        if (bit_end) begin
          rx_n = {rx[DATA_WIDTH-2:0], miso};
          if (bcnt == D_LAST) state_n = HOLD;
          else begin
            bcnt_n = bcnt + B_ONE;
            dsr_n = dsr << 1;
            mosi_n = dsr[DATA_WIDTH-2];
          end
        end
      end
      HOLD: if (half_end) begin
        state_n = DONE;
        ss_n = 1'b1;
        busy_n = 1'b0;
        done_n = 1'b1;
        mosi_n = 1'b0;
        rdata_n = rd ? rx : o_RDATA;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= IDLE;
      hcnt <= '0;
      bcnt <= '0;
      gcnt <= '0;
      asr <= '0;
      dsr <= '0;
      rx <= '0;
      rd <= 1'b0;
      o_RDATA <= '0;
      o_BCLK <= 1'b0;
      o_SS <= 1'b1;
      o_MOSI <= 1'b0;
      o_BUSY <= 1'b0;
      o_DONE <= 1'b0;
    end else begin
      state <= state_n;
      hcnt <= hcnt_n;
      bcnt <= bcnt_n;
      gcnt <= gcnt_n;
      asr <= asr_n;
      dsr <= dsr_n;
      rx <= rx_n;
      rd <= rd_n;
      o_RDATA <= rdata_n;
      o_BCLK <= bclk_n;
      o_SS <= ss_n;
      o_MOSI <= mosi_n;
      o_BUSY <= busy_n;
      o_DONE <= done_n;
    end
  end
endmodule
